bus_arbiter_rr4: RTL and testbench

- Round-robin arbiter and sequencer for a shared WIDTH-bit bus fed by four requesters through a 4:1 select path.
- Drives the 2-bit select of the 4:1 datapath and returns one-hot grants.
- Registers the selected word onto the shared bus output.
- Sits between four producer blocks (ALU result, register read port, I/O, constant source) and a single consumer bus.

---
 rtl/bus_arbiter_rr4.sv | 131 +++++++++++++
 tb/tb_bus_arbiter_rr4.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr4.sv
// Four-way round-robin bus arbiter: registered one-hot grant, mux select and shared-bus word.
// Optional macro BUS_ARB_HOLD_LIMIT_EN forces release after HOLD_MAX cycles when others are waiting.
module bus_arbiter_rr4 #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_bus_out;
  logic             r_bus_valid;

  logic             w_any;
  logic [1:0]       w_winner;
  logic [WIDTH-1:0] w_mux;
  logic [3:0]       w_owner_mask;
  logic             w_force;

  assign w_any        = |req;
  assign w_owner_mask = 4'b0001 << r_sel;

  // Scan from the farthest offset down so the nearest requester to ptr wins last.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_winner = r_ptr;
    idx      = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = r_ptr + 2'(k);
      if (req[idx]) w_winner = idx;
    end
  end

  always_comb begin
    unique case (r_sel)
      2'd0:    w_mux = data_a;
      2'd1:    w_mux = data_b;
      2'd2:    w_mux = data_c;
      default: w_mux = data_d;
    endcase
  end

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  logic [CW-1:0] r_hold;

  // Counter sits at zero outside GRANT and saturates at HOLD_LAST while the owner stays alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (r_state != S_GRANT) begin
      r_hold <= '0;
    end else if (r_hold != HOLD_LAST) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  assign w_force = (r_hold == HOLD_LAST) && |(req & ~w_owner_mask);
`else
  assign w_force = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_grant     <= 4'b0000;
      r_sel       <= 2'd0;
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_RELEASE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_grant <= 4'b0001 << w_winner;
            r_sel   <= w_winner;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (req[r_sel] && !w_force) begin
            r_bus_out   <= w_mux;
            r_bus_valid <= 1'b1;
          end else begin
            // Turnaround: sel is kept, bus_out holds, next search starts past the owner.
            r_state     <= S_RELEASE;
            r_grant     <= 4'b0000;
            r_bus_valid <= 1'b0;
            r_ptr       <= r_sel + 2'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_grant     <= 4'b0000;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign sel       = r_sel;
  assign bus_out   = r_bus_out;
  assign bus_valid = r_bus_valid;

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Directed self-checking bench for bus_arbiter_rr4; honours BUS_ARB_HOLD_LIMIT_EN if defined.
module tb_bus_arbiter_rr4;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [3:0]       req;
  logic [WIDTH-1:0] data_a, data_b, data_c, data_d;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic [WIDTH-1:0] bus_out;
  logic             bus_valid;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter_rr4 #(.WIDTH(WIDTH), .HOLD_MAX(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_a   (data_a),
    .data_b   (data_b),
    .data_c   (data_c),
    .data_d   (data_d),
    .grant    (grant),
    .sel      (sel),
    .bus_out  (bus_out),
    .bus_valid(bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous invariants: at most one grant bit, and no valid word without an owner.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if (!$onehot0(grant) || (bus_valid && grant == 4'b0000)) begin
        n_fail++;
        $display("FAIL invariant @%0t: grant=%b bus_valid=%b required onehot0 grant and valid only with owner",
                 $time, grant, bus_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    req    = 4'b0000;
    data_a = 8'h3C;
    data_b = 8'hA5;
    data_c = 8'h5A;
    data_d = 8'hC3;
    tick();
    n_checks++;
    if ({grant, sel, bus_out, bus_valid} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: got grant=%b sel=%b bus_out=%h valid=%b required all zero",
               grant, sel, bus_out, bus_valid);
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({grant, bus_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got grant=%b valid=%b required 0000/0", grant, bus_valid);
    end
  endtask

  task automatic test_single_owner();
    req = 4'b0001;
    tick();
    n_checks++;
    if ({grant, sel, bus_valid} !== {4'b0001, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b sel=%b valid=%b required 0001/00/0", grant, sel, bus_valid);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({grant, bus_valid, bus_out} !== {4'b0001, 1'b1, 8'h3C}) begin
        n_fail++;
        $display("FAIL single_data[%0d]: got grant=%b valid=%b bus_out=%h required 0001/1/3c",
                 c, grant, bus_valid, bus_out);
      end
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if ({grant, sel, bus_valid, bus_out} !== {4'b0000, 2'd0, 1'b0, 8'h3C}) begin
      n_fail++;
      $display("FAIL single_release: got grant=%b sel=%b valid=%b bus_out=%h required 0000/00/0/3c",
               grant, sel, bus_valid, bus_out);
    end
    tick();
    n_checks++;
    if ({grant, bus_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_idle: got grant=%b valid=%b required 0000/0", grant, bus_valid);
    end
  endtask

  // Follows test_single_owner, so ptr is 1 and requester 3 must beat requester 0.
  task automatic test_ptr_priority();
    req = 4'b1001;
    tick();
    n_checks++;
    if ({grant, sel} !== {4'b1000, 2'd3}) begin
      n_fail++;
      $display("FAIL ptr_grant3: got grant=%b sel=%b required 1000/11", grant, sel);
    end
    tick();
    n_checks++;
    if ({bus_valid, bus_out} !== {1'b1, 8'hC3}) begin
      n_fail++;
      $display("FAIL ptr_data3: got valid=%b bus_out=%h required 1/c3", bus_valid, bus_out);
    end
    req = 4'b0001;
    tick();
    n_checks++;
    if ({grant, sel, bus_valid} !== {4'b0000, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL ptr_release3: got grant=%b sel=%b valid=%b required 0000/11/0", grant, sel, bus_valid);
    end
    tick();
    n_checks++;
    if ({grant, sel} !== {4'b0001, 2'd0}) begin
      n_fail++;
      $display("FAIL ptr_wrap0: got grant=%b sel=%b required 0001/00", grant, sel);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [WIDTH-1:0] exp_d;
    int w;
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      w     = i % 4;
      exp_g = 4'b0001 << w;
      exp_d = (w == 0) ? data_a : (w == 1) ? data_b : (w == 2) ? data_c : data_d;
      n_checks++;
      if ({grant, sel} !== {exp_g, 2'(w)}) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got grant=%b sel=%b required %b/%0d", i, grant, sel, exp_g, w);
      end
      tick();
      n_checks++;
      if ({grant, bus_valid, bus_out} !== {exp_g, 1'b1, exp_d}) begin
        n_fail++;
        $display("FAIL rr_data[%0d]: got grant=%b valid=%b bus_out=%h required %b/1/%h",
                 i, grant, bus_valid, bus_out, exp_g, exp_d);
      end
      req[w] = 1'b0;
      tick();
      n_checks++;
      if ({grant, bus_valid} !== 5'b0) begin
        n_fail++;
        $display("FAIL rr_dead[%0d]: got grant=%b valid=%b required 0000/0", i, grant, bus_valid);
      end
      req = 4'b1111;
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    n_checks++;
    if ({grant, sel, bus_valid, bus_out} !== {4'b0100, 2'd2, 1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL mid_pre: got grant=%b sel=%b valid=%b bus_out=%h required 0100/10/1/5a",
               grant, sel, bus_valid, bus_out);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({grant, sel, bus_out, bus_valid} !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got grant=%b sel=%b bus_out=%h valid=%b required all zero",
               grant, sel, bus_out, bus_valid);
    end
    #1 reset = 1'b0;
    tick();
    n_checks++;
    if ({grant, sel, bus_valid} !== {4'b0100, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_regrant: got grant=%b sel=%b valid=%b required 0100/10/0", grant, sel, bus_valid);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_pulse_ignored();
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    req = 4'b0011;
    tick();
    n_checks++;
    if ({grant, sel, bus_valid} !== {4'b0001, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL pulse_owner_kept: got grant=%b sel=%b valid=%b required 0001/00/1", grant, sel, bus_valid);
    end
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL pulse_no_grant[%0d]: got grant=%b required 0000", c, grant);
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b0011;
    tick();
    for (int c = 0; c < 14; c++) begin
`ifdef BUS_ARB_HOLD_LIMIT_EN
      // Pattern of period 5: four cycles owner, one dead cycle, owners alternate 0,1,0.
      exp_g = ((c % 5) == 4) ? 4'b0000 : (((c / 5) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      n_checks++;
      if (grant !== exp_g) begin
        n_fail++;
        $display("FAIL hold_pair[%0d]: got grant=%b required %b", c, grant, exp_g);
      end
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_hold_alone();
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0001) begin
        n_fail++;
        $display("FAIL hold_alone[%0d]: got grant=%b required 0001", c, grant);
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    req    = 4'b0000;
    data_a = '0;
    data_b = '0;
    data_c = '0;
    data_d = '0;
    test_reset();
    test_single_owner();
    test_ptr_priority();
    test_round_robin();
    test_reset_mid_grant();
    test_pulse_ignored();
    test_hold_limit();
    test_hold_alone();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
